// File: rtl/npu_result_writeback.sv
// npu_result_writeback
//   Write-back unit for the NPU layer pipeline. Accepts LANES x DW result
//   vectors over a valid/ready handshake and serializes them one byte per
//   cycle into the single-port result RAM. The bytes go to consecutive
//   addresses starting at a programmed base. One start pulse writes
//   num_vectors vectors, and a one-cycle done pulse reports completion.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   one-cycle launch pulse, honoured only in IDLE
//   base_addr    in   first RAM address, latched on accepted start
//   num_vectors  in   vectors to write, latched on accepted start
//   in_valid     in   result vector present on in_data
//   in_data      in   lane k on bits [k*DW+DW-1 : k*DW]
//   in_ready     out  unit accepts a vector this cycle (WAIT state)
//   ram_wr_en    out  RAM write strobe
//   ram_addr     out  RAM write address
//   ram_wdata    out  RAM write data (optionally ReLU-clamped)
//   lane_idx     out  lane currently on ram_wdata
//   busy         out  high in every state except IDLE
//   done         out  one-cycle completion pulse
module npu_result_writeback #(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int AW    = 14,
  parameter bit RELU  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [9:0]          num_vectors,
  input  logic                in_valid,
  input  logic [LANES*DW-1:0] in_data,
  output logic                in_ready,
  output logic                ram_wr_en,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_wdata,
  output logic [3:0]          lane_idx,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_r;
  logic [AW-1:0]       addr_cnt_r;   // next address to be written
  logic [9:0]          remain_r;     // vectors still to be written
  logic [LANES*DW-1:0] vec_r;        // vector being serialized
  logic [3:0]          lane_next_s;
  logic [DW-1:0]       byte_next_s;

  localparam logic [3:0]    LAST_LANE = 4'(LANES - 1);
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  // Negative lanes clamp to zero when the ReLU build option is set.
  function automatic logic [DW-1:0] relu_f(input logic [DW-1:0] v);
    if (RELU && v[DW-1]) begin
      relu_f = {DW{1'b0}};
    end else begin
      relu_f = v;
    end
  endfunction

  // Ready is a pure state decode so there is no path from in_valid.
  assign in_ready = (state_r == S_WAIT);

  // Select the byte for the next lane out of the held vector.
  always_comb begin
    lane_next_s = lane_idx + 4'd1;
    byte_next_s = relu_f(vec_r[lane_next_s*DW +: DW]);
  end

  // Main FSM. The RAM port registers lead the state by one lane: lane 0 is
  // loaded on the handshake edge straight from in_data, and lanes 1..15
  // come from vec_r. lane_idx therefore names the lane currently on the port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      addr_cnt_r <= {AW{1'b0}};
      remain_r   <= 10'd0;
      vec_r      <= {(LANES*DW){1'b0}};
      ram_wr_en  <= 1'b0;
      ram_addr   <= {AW{1'b0}};
      ram_wdata  <= {DW{1'b0}};
      lane_idx   <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            addr_cnt_r <= base_addr;
            remain_r   <= num_vectors;
            busy       <= 1'b1;
            if (num_vectors == 10'd0) begin
              state_r <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_r <= S_WAIT;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (in_valid) begin
            vec_r      <= in_data;
            ram_wr_en  <= 1'b1;
            ram_addr   <= addr_cnt_r;
            ram_wdata  <= relu_f(in_data[DW-1:0]);
            lane_idx   <= 4'd0;
            addr_cnt_r <= addr_cnt_r + ADDR_ONE;
            state_r    <= S_WRITE;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_WRITE: begin
          if (lane_idx == LAST_LANE) begin
            ram_wr_en <= 1'b0;
            remain_r  <= remain_r - 10'd1;
            if (remain_r == 10'd1) begin
              state_r <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_r <= S_WAIT;
            end
          end else begin
            ram_addr   <= addr_cnt_r;
            ram_wdata  <= byte_next_s;
            lane_idx   <= lane_next_s;
            addr_cnt_r <= addr_cnt_r + ADDR_ONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          ram_wr_en <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npu_result_writeback.sv
module tb_npu_result_writeback;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [13:0]  base_addr;
  logic [9:0]   num_vectors;
  logic         in_valid;
  logic [127:0] in_data;

  logic         in_ready, ram_wr_en, busy, done;
  logic [13:0]  ram_addr;
  logic [7:0]   ram_wdata;
  logic [3:0]   lane_idx;

  logic         r_in_ready, r_ram_wr_en, r_busy, r_done;
  logic [13:0]  r_ram_addr;
  logic [7:0]   r_ram_wdata;
  logic [3:0]   r_lane_idx;

  int nvec = 0;
  int nerr = 0;
  logic [127:0] vecs [0:3];

  always #5 clk = ~clk;

  npu_result_writeback #(.LANES(16), .DW(8), .AW(14), .RELU(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_vectors(num_vectors), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .lane_idx(lane_idx), .busy(busy), .done(done)
  );

  npu_result_writeback #(.LANES(16), .DW(8), .AW(14), .RELU(1'b1)) dut_r (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_vectors(num_vectors), .in_valid(in_valid), .in_data(in_data),
    .in_ready(r_in_ready), .ram_wr_en(r_ram_wr_en), .ram_addr(r_ram_addr),
    .ram_wdata(r_ram_wdata), .lane_idx(r_lane_idx), .busy(r_busy), .done(r_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one start..done job. mode 0 holds in_valid high; mode 1 drops
  // in_valid after each handshake, pulses in_valid/start with junk data at
  // lane 5, and leaves a 10-cycle gap in WAIT before offering the next vector.
  task automatic run_job(input string tag, input logic [13:0] base, input logic [9:0] num,
                         input int mode, input int exp_cycles, input int exp_rdy);
    int widx = 0, rdy = 0, done_c = -1, vi = 0, since = 100;
    logic hs;
    logic [13:0] ea;
    logic [7:0]  eb, er;
    logic [127:0] saved;
    logic [127:0] junk;
    junk = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    saved = 128'd0;
    base_addr = base; num_vectors = num; start = 1'b1;
    in_valid = 1'b1; in_data = vecs[0];
    tick();
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (in_ready) rdy++;
      if (ram_wr_en) begin
        ea = base + 14'(widx);
        eb = vecs[(widx / 16) % 4][(widx % 16) * 8 +: 8];
        er = eb[7] ? 8'h00 : eb;
        chk({tag, " addr"}, 32'(ram_addr), 32'(ea));
        chk({tag, " data"}, 32'(ram_wdata), 32'(eb));
        chk({tag, " lane"}, 32'(lane_idx), 32'(widx % 16));
        chk({tag, " relu data"}, 32'(r_ram_wdata), 32'(er));
        widx++;
      end
      if (ram_wr_en && in_ready) chk({tag, " ready during write"}, 32'(1), 32'(0));
      if (done) begin
        done_c = c;
        break;
      end
      hs = in_ready && in_valid;
      tick();
      if (hs) begin
        vi++;
        since = 0;
        in_data = vecs[vi % 4];
        if (mode == 1) in_valid = 1'b0;
      end else begin
        since++;
      end
      if (mode == 1) begin
        if (since == 5) begin
          saved = in_data; in_data = junk; in_valid = 1'b1; start = 1'b1;
        end
        if (since == 6) begin
          in_data = saved; in_valid = 1'b0; start = 1'b0;
        end
        if (since == 26) in_valid = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk({tag, " write count"}, 32'(widx), 32'(num) * 32'd16);
    chk({tag, " ready cycles"}, 32'(rdy), 32'(exp_rdy));
    chk({tag, " done cycle"}, 32'(done_c), 32'(exp_cycles));
    chk({tag, " busy at done"}, 32'(busy), 32'(1));
    chk({tag, " wr_en at done"}, 32'(ram_wr_en), 32'(0));
    tick();
    chk({tag, " done falls"}, 32'(done), 32'(0));
    chk({tag, " busy falls"}, 32'(busy), 32'(0));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = 14'd0; num_vectors = 10'd0;
    in_valid = 1'b0; in_data = 128'd0;
    for (int i = 0; i < 4; i++) vecs[i] = 128'd0;

    // Reset values after 3 cycles in reset.
    tick(); tick(); tick();
    chk("rst in_ready", 32'(in_ready), 32'(0));
    chk("rst ram_wr_en", 32'(ram_wr_en), 32'(0));
    chk("rst ram_addr", 32'(ram_addr), 32'(0));
    chk("rst ram_wdata", 32'(ram_wdata), 32'(0));
    chk("rst lane_idx", 32'(lane_idx), 32'(0));
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst done", 32'(done), 32'(0));
    reset = 1'b1;
    tick();

    // Single vector, lanes k+1, base 100.
    for (int k = 0; k < 16; k++) vecs[0][k*8 +: 8] = 8'(k + 1);
    run_job("single", 14'd100, 10'd1, 0, 17, 1);

    // Back-to-back three vectors with in_valid held high.
    for (int k = 0; k < 16; k++) begin
      vecs[0][k*8 +: 8] = 8'(8'h10 + k);
      vecs[1][k*8 +: 8] = 8'(8'hA0 + k);
      vecs[2][k*8 +: 8] = 8'(8'h30 + 2 * k);
    end
    run_job("b2b", 14'd100, 10'd3, 0, 51, 3);

    // Gap between vectors plus spurious in_valid/start during WRITE.
    for (int k = 0; k < 16; k++) begin
      vecs[0][k*8 +: 8] = 8'(8'h55 ^ k);
      vecs[1][k*8 +: 8] = 8'(8'hC0 + 3 * k);
    end
    run_job("stall", 14'd200, 10'd2, 1, 44, 12);

    // Address wrap at the top of the RAM.
    for (int k = 0; k < 16; k++) vecs[0][k*8 +: 8] = 8'(8'hE0 + k);
    run_job("wrap", 14'd16376, 10'd1, 0, 17, 1);

    // ReLU lanes: 0x80, 0xFF, 0x00, 0x7F.
    vecs[0] = 128'd0;
    vecs[0][7:0] = 8'h80; vecs[0][15:8] = 8'hFF; vecs[0][23:16] = 8'h00; vecs[0][31:24] = 8'h7F;
    run_job("relu", 14'd300, 10'd1, 0, 17, 1);

    // Zero vectors: done one cycle after start, no writes.
    base_addr = 14'd50; num_vectors = 10'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero done", 32'(done), 32'(1));
    chk("zero wr_en", 32'(ram_wr_en), 32'(0));
    chk("zero busy", 32'(busy), 32'(1));
    tick();
    chk("zero done falls", 32'(done), 32'(0));
    chk("zero wr_en after", 32'(ram_wr_en), 32'(0));

    // Reset asserted mid-WRITE at lane 5.
    base_addr = 14'd500; num_vectors = 10'd1; start = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 16; k++) in_data[k*8 +: 8] = 8'(8'h40 + k);
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("midrst lane before", 32'(lane_idx), 32'(5));
    chk("midrst wr_en before", 32'(ram_wr_en), 32'(1));
    chk("midrst addr before", 32'(ram_addr), 32'(505));
    #2 reset = 1'b0;
    #1;
    chk("midrst wr_en async", 32'(ram_wr_en), 32'(0));
    chk("midrst busy async", 32'(busy), 32'(0));
    chk("midrst lane async", 32'(lane_idx), 32'(0));
    tick();
    reset = 1'b1;
    chk("midrst no lane6", 32'(ram_wr_en), 32'(0));
    tick();
    chk("midrst idle wr_en", 32'(ram_wr_en), 32'(0));
    chk("midrst idle ready", 32'(in_ready), 32'(0));
    tick();
    chk("midrst idle busy", 32'(busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
